// File: rtl/line_buf_sched.sv
// line_buf_sched: rotates line-buffer banks per input line, drives the shared pixel address,
// per-bank write enables and edge-replicate tap selects, and self-times the bottom flush rows.
module line_buf_sched #(
    parameter int PAD_SIZE = 2,
    parameter int HAC      = 1920,
    parameter int VAC      = 1080,
    parameter int HBLANK   = 8,
    parameter int ADDR_W   = 11,
    parameter int BANK_W   = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_vs,
    input  logic                               i_hs,
    input  logic                               i_de,
    output logic [ADDR_W-1:0]                  o_addr,
    output logic [2*PAD_SIZE-1:0]              o_we,
    output logic [(2*PAD_SIZE+1)*BANK_W-1:0]   o_tap_sel,
    output logic                               o_de,
    output logic                               o_vs,
    output logic [11:0]                        o_row,
    output logic                               o_done,
    output logic                               o_err
);
    localparam int NUM_BANK = 2 * PAD_SIZE;
    localparam int NTAP     = 2 * PAD_SIZE + 1;
    localparam int CW       = ADDR_W + 1;
    localparam int FW       = $clog2(HBLANK + HAC + 1);
    localparam logic [CW-1:0] HAC_L   = CW'(HAC);
    localparam logic [CW-1:0] HLAST_L = CW'(HAC - 1);
    localparam logic [11:0]   VAC_L   = 12'(VAC);
    localparam logic [11:0]   PAD_L   = 12'(PAD_SIZE);
    localparam logic [11:0]   FROW_L  = 12'(PAD_SIZE - 1);
    localparam logic [FW-1:0] HB_L    = FW'(HBLANK);
    localparam logic [FW-1:0] FEND_L  = FW'(HBLANK + HAC - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               col_q, col_d;
    logic [11:0]                 line_q, line_d;
    logic [11:0]                 frow_q, frow_d;
    logic [FW-1:0]               fl_q, fl_d;
    logic                        extra_q, extra_d;
    logic                        last_q, last_d;
    logic [ADDR_W-1:0]           addr_q, addr_d;
    logic [NUM_BANK-1:0]         we_q, we_d;
    logic [NTAP*BANK_W-1:0]      tap_q, tap_d, tap_w;
    logic                        de_q, de_d, vs_q, vs_d, done_q, done_d, err_q, err_d;
    logic [11:0]                 row_q, row_d;
    int                          r_i;

    // line_q counts lines started, so the row being written is line_q-1
    always_comb r_i = state_q == FLUSH ? VAC - PAD_SIZE + int'(frow_q) : int'(line_q) - 1 - PAD_SIZE;

    always_comb begin
        int s;
        s = 0;
        tap_w = '0;
        for (int t = 0; t < NTAP; t++) begin
            s = r_i + t - PAD_SIZE;
            s = s < 0 ? 0 : s > VAC - 1 ? VAC - 1 : s;
            tap_w[t*BANK_W +: BANK_W] = (state_q == RUN && t == 2 * PAD_SIZE) ? BANK_W'(NUM_BANK) : BANK_W'(s % NUM_BANK);
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        line_d  = line_q;
        frow_d  = frow_q;
        fl_d    = fl_q;
        extra_d = extra_q;
        last_d  = 1'b0;
        done_d  = last_q;
        err_d   = 1'b0;
        we_d    = '0;
        de_d    = 1'b0;
        vs_d    = 1'b0;
        addr_d  = addr_q;
        row_d   = row_q;
        tap_d   = tap_q;
        if (i_vs) begin
            state_d = FILL;
            col_d   = '0;
            line_d  = i_hs ? 12'd1 : 12'd0;
            frow_d  = '0;
            fl_d    = '0;
            extra_d = 1'b0;
            row_d   = '0;
            err_d   = state_q != IDLE;
        end else if (state_q == FILL || state_q == RUN) begin
            if (i_hs) begin
                err_d   = line_q != '0 && col_q != HAC_L;
                col_d   = '0;
                extra_d = 1'b0;
                line_d  = line_q + 12'd1;
                if (state_q == FILL && line_q == PAD_L)
                    state_d = RUN;
                else if (state_q == RUN && line_q == VAC_L)
                    state_d = FLUSH;
            end else if (i_de && line_q != '0) begin
                if (col_q == HAC_L) begin
                    err_d   = !extra_q;
                    extra_d = 1'b1;
                end else begin
                    col_d  = col_q + CW'(1);
                    we_d   = NUM_BANK'(1) << ((int'(line_q) - 1) % NUM_BANK);
                    addr_d = col_q[ADDR_W-1:0];
                    de_d   = state_q == RUN;
                    vs_d   = state_q == RUN && r_i == 0 && col_q == '0;
                    if (state_q == RUN && line_q == VAC_L && col_q == HLAST_L)
                        state_d = FLUSH;
                end
            end
        end else if (state_q == FLUSH) begin
            err_d = i_hs | i_de;
            if (fl_q >= HB_L) begin
                de_d   = 1'b1;
                addr_d = ADDR_W'(fl_q - HB_L);
            end
            if (fl_q == FEND_L) begin
                fl_d   = '0;
                frow_d = frow_q + 12'd1;
                if (frow_q == FROW_L) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end
            end else begin
                fl_d = fl_q + FW'(1);
            end
        end
        if (de_d) begin
            row_d = 12'(r_i);
            tap_d = tap_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            line_q  <= '0;
            frow_q  <= '0;
            fl_q    <= '0;
            extra_q <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            we_q    <= '0;
            tap_q   <= '0;
            de_q    <= 1'b0;
            vs_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            line_q  <= line_d;
            frow_q  <= frow_d;
            fl_q    <= fl_d;
            extra_q <= extra_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            tap_q   <= tap_d;
            de_q    <= de_d;
            vs_q    <= vs_d;
            done_q  <= done_d;
            err_q   <= err_d;
            row_q   <= row_d;
        end
    end

    assign o_addr    = addr_q;
    assign o_we      = we_q;
    assign o_tap_sel = tap_q;
    assign o_de      = de_q;
    assign o_vs      = vs_q;
    assign o_row     = row_q;
    assign o_done    = done_q;
    assign o_err     = err_q;
endmodule

// File: tb/tb_line_buf_sched.sv
// tb_line_buf_sched: directed frames (nominal, abort, line-length errors, reset in flush)
// with hand-computed bank rotation, tap selects and pulse counts.
module tb_line_buf_sched;
    logic clk = 1'b0, rst = 1'b1, i_vs = 1'b0, i_hs = 1'b0, i_de = 1'b0;
    logic [10:0] o_addr;
    logic [3:0]  o_we;
    logic [14:0] o_tap_sel;
    logic        o_de, o_vs, o_done, o_err;
    logic [11:0] o_row;

    int checks = 0, failures = 0;
    int de_cnt = 0, done_cnt = 0, err_cnt = 0, vs_cnt = 0, vs_ok = 0, de_at_done = 0, nw = 0, nr = 0;
    int b_de, b_done, b_err, b_vs, b_vsok, b_nw, b_nr;
    logic [3:0]  we_log [1024];
    logic [10:0] wa_log [1024];
    logic [11:0] row_log [256];
    logic [14:0] tap_log [256];
    logic [14:0] exp_tap [6];
    logic [3:0]  exp_we [6];

    line_buf_sched #(.PAD_SIZE(2), .HAC(8), .VAC(6), .HBLANK(4), .ADDR_W(11), .BANK_W(3)) dut (
        .clk(clk), .rst(rst), .i_vs(i_vs), .i_hs(i_hs), .i_de(i_de),
        .o_addr(o_addr), .o_we(o_we), .o_tap_sel(o_tap_sel), .o_de(o_de), .o_vs(o_vs),
        .o_row(o_row), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_de) de_cnt++;
        if (o_done) begin
            done_cnt++;
            de_at_done = de_cnt;
        end
        if (o_err) err_cnt++;
        if (o_vs) begin
            vs_cnt++;
            if (o_de && o_row == 12'd0 && o_addr == 11'd0) vs_ok++;
        end
        if (o_we != 4'd0 && nw < 1024) begin
            we_log[nw] = o_we;
            wa_log[nw] = o_addr;
            nw++;
        end
        if (o_de && o_addr == 11'd0 && nr < 256) begin
            row_log[nr] = o_row;
            tap_log[nr] = o_tap_sel;
            nr++;
        end
    end

    function automatic logic [14:0] tp(input int a0, input int a1, input int a2, input int a3, input int a4);
        return {3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic snap;
        b_de = de_cnt; b_done = done_cnt; b_err = err_cnt; b_vs = vs_cnt;
        b_vsok = vs_ok; b_nw = nw; b_nr = nr;
    endtask

    task automatic vs_pulse;
        step(); i_vs = 1'b1;
        step(); i_vs = 1'b0;
    endtask

    task automatic send_line(input int n);
        step(); i_hs = 1'b1;
        step(); i_hs = 1'b0;
        for (int i = 0; i < n; i++) begin
            i_de = 1'b1;
            step();
        end
        i_de = 1'b0;
        repeat (2) step();
    endtask

    task automatic wait_done;
        int t;
        t = 0;
        while (done_cnt == b_done && t < 300) begin
            step();
            t++;
        end
        repeat (3) step();
        chk("done_once", done_cnt - b_done, 1);
    endtask

    task automatic check_rows(input string tag);
        for (int r = 0; r < 6; r++) begin
            chk($sformatf("%s_row%0d", tag, r), row_log[b_nr + r], r);
            chk($sformatf("%s_tap%0d", tag, r), tap_log[b_nr + r], exp_tap[r]);
        end
        chk({tag, "_rows"}, nr - b_nr, 6);
        chk({tag, "_de_total"}, de_cnt - b_de, 48);
        chk({tag, "_de_at_done"}, de_at_done - b_de, 48);
    endtask

    task automatic check_we(input string tag);
        for (int l = 0; l < 6; l++)
            chk($sformatf("%s_we_line%0d", tag, l), we_log[b_nw + 8 * l], exp_we[l]);
        chk({tag, "_writes"}, nw - b_nw, 48);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_addr"}, o_addr, 0);
        chk({tag, "_we"}, o_we, 0);
        chk({tag, "_tap"}, o_tap_sel, 0);
        chk({tag, "_row"}, o_row, 0);
        chk({tag, "_flags"}, {o_de, o_vs, o_done, o_err}, 0);
    endtask

    initial begin
        exp_tap[0] = tp(0, 0, 0, 1, 4);
        exp_tap[1] = tp(0, 0, 1, 2, 4);
        exp_tap[2] = tp(0, 1, 2, 3, 4);
        exp_tap[3] = tp(1, 2, 3, 0, 4);
        exp_tap[4] = tp(2, 3, 0, 1, 1);
        exp_tap[5] = tp(3, 0, 1, 1, 1);
        exp_we = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

        repeat (3) step();
        @(negedge clk);
        check_zero("reset");
        step();
        rst = 1'b0;

        snap();
        vs_pulse();
        send_line(8);
        send_line(8);
        chk("fill_no_de", de_cnt - b_de, 0);
        repeat (4) send_line(8);
        wait_done();
        check_rows("nom");
        check_we("nom");
        chk("nom_err", err_cnt - b_err, 0);
        chk("nom_vs", vs_cnt - b_vs, 1);
        chk("nom_vs_pos", vs_ok - b_vsok, 1);

        snap();
        vs_pulse();
        repeat (3) send_line(8);
        send_line(3);
        vs_pulse();
        repeat (2) step();
        chk("abort_err", err_cnt - b_err, 1);
        chk("abort_no_done", done_cnt - b_done, 0);
        snap();
        repeat (6) send_line(8);
        wait_done();
        check_rows("abort");
        chk("abort_next_err", err_cnt - b_err, 0);

        snap();
        vs_pulse();
        send_line(10);
        chk("extra_err", err_cnt - b_err, 1);
        chk("extra_writes", nw - b_nw, 8);
        chk("extra_last_addr", wa_log[nw - 1], 7);
        send_line(5);
        send_line(8);
        chk("cut_err", err_cnt - b_err, 2);
        chk("cut_writes", nw - b_nw, 21);
        chk("cut_next_addr0", wa_log[b_nw + 13], 0);
        repeat (3) send_line(8);
        wait_done();
        chk("len_de", de_cnt - b_de, 48);
        chk("len_err", err_cnt - b_err, 2);

        snap();
        vs_pulse();
        repeat (6) send_line(8);
        repeat (4) step();
        rst = 1'b1;
        step();
        @(negedge clk);
        check_zero("flush_rst");
        chk("flush_rst_in_flush", (de_cnt - b_de) > 32, 1);
        step();
        rst = 1'b0;
        repeat (40) step();
        chk("flush_rst_no_done", done_cnt - b_done, 0);
        snap();
        vs_pulse();
        repeat (6) send_line(8);
        wait_done();
        check_rows("post_rst");
        check_we("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
